// File: rtl/ahbl_arb2.sv
// Two-master AHB-Lite arbiter in front of a single AHB-Lite slave.
// The losing master's address phase is parked in a 1-entry buffer and replayed on the next free slot.
module ahbl_arb2 #(
  parameter logic RR_EN = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [1:0]  M0_HTRANS,
  input  logic [31:0] M0_HADDR,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic        M0_HMASTLOCK,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic        M0_HRESP,
  output logic [31:0] M0_HRDATA,
  input  logic [1:0]  M1_HTRANS,
  input  logic [31:0] M1_HADDR,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic        M1_HMASTLOCK,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic        M1_HRESP,
  output logic [31:0] M1_HRDATA,
  output logic        S_HSEL,
  output logic [1:0]  S_HTRANS,
  output logic [31:0] S_HADDR,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [31:0] S_HWDATA,
  output logic        S_HREADY,
  input  logic        S_HREADYOUT,
  input  logic        S_HRESP,
  input  logic [31:0] S_HRDATA
);

  typedef struct packed {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic        lock;
  } addr_ph_t;

  addr_ph_t   live_s [2];
  addr_ph_t   req_s  [2];
  addr_ph_t   pend_r [2];
  logic [1:0] pend_vld_r;
  logic [1:0] dp_r;
  logic [1:0] hready_s;
  logic [1:0] act_s;
  logic [1:0] gnt_s;
  logic [1:0] capture_s;
  logic       last_grant_r;
  logic       lock_r;
  logic       win_s;
  logic       issue_s;

  // Per-master live address phase, ready and effective request (buffered entry has precedence)
  always_comb begin
    live_s[0] = {M0_HTRANS, M0_HADDR, M0_HWRITE, M0_HSIZE, M0_HMASTLOCK};
    live_s[1] = {M1_HTRANS, M1_HADDR, M1_HWRITE, M1_HSIZE, M1_HMASTLOCK};
    for (int m = 0; m < 2; m++) begin
      hready_s[m] = dp_r[m] ? S_HREADYOUT : ~pend_vld_r[m];
      req_s[m]    = live_s[m];
      act_s[m]    = 1'b0;
      if (pend_vld_r[m]) begin
        req_s[m] = pend_r[m];
        act_s[m] = pend_r[m].trans[1];
      end else if (hready_s[m]) begin
        act_s[m] = live_s[m].trans[1];
      end else begin
        act_s[m] = 1'b0;
      end
    end
  end

  // Winner selection; a locked issuer that is still requesting keeps the slave
  always_comb begin
    win_s = 1'b0;
    if (act_s[0] && act_s[1]) begin
      if (lock_r) begin
        win_s = last_grant_r;
      end else if (RR_EN) begin
        win_s = ~last_grant_r;
      end else begin
        win_s = 1'b0;
      end
    end else if (act_s[1]) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    issue_s   = S_HREADYOUT & (|act_s);
    gnt_s     = issue_s ? (win_s ? 2'b10 : 2'b01) : 2'b00;
    capture_s = hready_s & {live_s[1].trans[1], live_s[0].trans[1]} & ~gnt_s;
  end

  // Slave-side address phase and per-master response routing
  always_comb begin
    S_HSEL    = issue_s;
    S_HTRANS  = issue_s ? req_s[win_s].trans : 2'b00;
    S_HADDR   = req_s[win_s].addr;
    S_HWRITE  = req_s[win_s].write;
    S_HSIZE   = req_s[win_s].size;
    S_HWDATA  = dp_r[1] ? M1_HWDATA : M0_HWDATA;
    S_HREADY  = S_HREADYOUT;
    M0_HREADY = hready_s[0];
    M1_HREADY = hready_s[1];
    M0_HRESP  = dp_r[0] ? S_HRESP : 1'b0;
    M1_HRESP  = dp_r[1] ? S_HRESP : 1'b0;
    M0_HRDATA = S_HRDATA;
    M1_HRDATA = S_HRDATA;
  end

  // Data-phase ownership, grant history and address buffers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_r         <= 2'b00;
      pend_vld_r   <= 2'b00;
      last_grant_r <= 1'b1;
      lock_r       <= 1'b0;
      pend_r[0]    <= '0;
      pend_r[1]    <= '0;
    end else begin
      // Ownership only moves when the current data phase completes
      if (S_HREADYOUT) begin
        dp_r <= gnt_s;
      end
      if (issue_s) begin
        last_grant_r <= win_s;
        lock_r       <= req_s[win_s].lock;
      end
      pend_vld_r <= (pend_vld_r & ~gnt_s) | capture_s;
      for (int m = 0; m < 2; m++) begin
        if (capture_s[m]) begin
          pend_r[m] <= live_s[m];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahbl_arb2.sv
// Directed bench for ahbl_arb2: round-robin instance with a small memory slave,
// plus a fixed-priority instance on the same master stimulus.
module tb_ahbl_arb2;

  logic        HCLK;
  logic        HRESETn;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
  logic        M0_HWRITE, M1_HWRITE, M0_HMASTLOCK, M1_HMASTLOCK;
  logic [2:0]  M0_HSIZE, M1_HSIZE;
  logic        M0_HREADY, M1_HREADY, M0_HRESP, M1_HRESP;
  logic [31:0] M0_HRDATA, M1_HRDATA;
  logic        S_HSEL, S_HWRITE, S_HREADY, S_HREADYOUT, S_HRESP;
  logic [1:0]  S_HTRANS;
  logic [31:0] S_HADDR, S_HWDATA, S_HRDATA;
  logic [2:0]  S_HSIZE;

  logic        fp_m0_hready, fp_m1_hready, fp_m0_hresp, fp_m1_hresp;
  logic [31:0] fp_m0_hrdata, fp_m1_hrdata;
  logic        fp_s_hsel, fp_s_hwrite, fp_s_hready;
  logic [1:0]  fp_s_htrans;
  logic [31:0] fp_s_haddr, fp_s_hwdata;
  logic [2:0]  fp_s_hsize;

  int checks = 0;
  int errors = 0;

  ahbl_arb2 #(.RR_EN(1'b1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HTRANS(M0_HTRANS), .M0_HADDR(M0_HADDR), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY),
    .M0_HRESP(M0_HRESP), .M0_HRDATA(M0_HRDATA),
    .M1_HTRANS(M1_HTRANS), .M1_HADDR(M1_HADDR), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY),
    .M1_HRESP(M1_HRESP), .M1_HRDATA(M1_HRDATA),
    .S_HSEL(S_HSEL), .S_HTRANS(S_HTRANS), .S_HADDR(S_HADDR), .S_HWRITE(S_HWRITE),
    .S_HSIZE(S_HSIZE), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
    .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .S_HRDATA(S_HRDATA)
  );

  ahbl_arb2 #(.RR_EN(1'b0)) dut_fp (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HTRANS(M0_HTRANS), .M0_HADDR(M0_HADDR), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
    .M0_HMASTLOCK(M0_HMASTLOCK), .M0_HWDATA(M0_HWDATA), .M0_HREADY(fp_m0_hready),
    .M0_HRESP(fp_m0_hresp), .M0_HRDATA(fp_m0_hrdata),
    .M1_HTRANS(M1_HTRANS), .M1_HADDR(M1_HADDR), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
    .M1_HMASTLOCK(M1_HMASTLOCK), .M1_HWDATA(M1_HWDATA), .M1_HREADY(fp_m1_hready),
    .M1_HRESP(fp_m1_hresp), .M1_HRDATA(fp_m1_hrdata),
    .S_HSEL(fp_s_hsel), .S_HTRANS(fp_s_htrans), .S_HADDR(fp_s_haddr), .S_HWRITE(fp_s_hwrite),
    .S_HSIZE(fp_s_hsize), .S_HWDATA(fp_s_hwdata), .S_HREADY(fp_s_hready),
    .S_HREADYOUT(1'b1), .S_HRESP(1'b0), .S_HRDATA(32'h0000_0000)
  );

  // Memory slave model: 64 words preloaded with 0x1000_0000 + index, optional wait state
  logic [31:0] mem [0:63];
  logic        sl_act_r, sl_write_r, wait_r;
  logic [5:0]  sl_idx_r;

  assign S_HREADYOUT = ~wait_r;
  assign S_HRESP     = 1'b0;
  assign S_HRDATA    = (sl_act_r && !sl_write_r) ? mem[sl_idx_r] : 32'h0000_0000;

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sl_act_r   <= 1'b0;
      sl_write_r <= 1'b0;
      sl_idx_r   <= 6'd0;
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
    end else if (S_HREADY) begin
      if (sl_act_r && sl_write_r) mem[sl_idx_r] <= S_HWDATA;
      sl_act_r   <= S_HSEL & S_HTRANS[1];
      sl_write_r <= S_HWRITE;
      sl_idx_r   <= S_HADDR[7:2];
    end
  end

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next_cyc;
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_all;
    M0_HTRANS = 2'b00; M0_HADDR = 32'h0; M0_HWRITE = 1'b0; M0_HSIZE = 3'b010;
    M0_HMASTLOCK = 1'b0; M0_HWDATA = 32'h0;
    M1_HTRANS = 2'b00; M1_HADDR = 32'h0; M1_HWRITE = 1'b0; M1_HSIZE = 3'b010;
    M1_HMASTLOCK = 1'b0; M1_HWDATA = 32'h0;
  endtask

  task automatic drv0(input logic [1:0] t, input logic [31:0] a, input logic w, input logic l);
    M0_HTRANS = t; M0_HADDR = a; M0_HWRITE = w; M0_HMASTLOCK = l;
  endtask

  task automatic drv1(input logic [1:0] t, input logic [31:0] a, input logic w, input logic l);
    M1_HTRANS = t; M1_HADDR = a; M1_HWRITE = w; M1_HMASTLOCK = l;
  endtask

  task automatic do_reset;
    HRESETn = 1'b0;
    wait_r  = 1'b0;
    idle_all();
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
  endtask

  task automatic test_reset;
    HRESETn = 1'b0;
    wait_r  = 1'b0;
    idle_all();
    @(negedge HCLK);
    checks++; if (S_HSEL !== 1'b0) begin errors++; $display("FAIL rst_hsel got %b exp 0", S_HSEL); end
    checks++; if (S_HTRANS !== 2'b00) begin errors++; $display("FAIL rst_htrans got %b exp 00", S_HTRANS); end
    checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("FAIL rst_m0_hready got %b exp 1", M0_HREADY); end
    checks++; if (M1_HREADY !== 1'b1) begin errors++; $display("FAIL rst_m1_hready got %b exp 1", M1_HREADY); end
    checks++; if (M0_HRESP !== 1'b0) begin errors++; $display("FAIL rst_m0_hresp got %b exp 0", M0_HRESP); end
    checks++; if (M1_HRESP !== 1'b0) begin errors++; $display("FAIL rst_m1_hresp got %b exp 0", M1_HRESP); end
  endtask

  task automatic test_m0_alone;
    do_reset();
    drv0(2'b10, 32'h10, 1'b1, 1'b0);
    @(negedge HCLK);
    checks++; if (S_HSEL !== 1'b1) begin errors++; $display("FAIL t1_w_hsel got %b exp 1", S_HSEL); end
    checks++; if (S_HADDR !== 32'h10) begin errors++; $display("FAIL t1_w_haddr got %h exp 10", S_HADDR); end
    checks++; if (S_HWRITE !== 1'b1) begin errors++; $display("FAIL t1_w_hwrite got %b exp 1", S_HWRITE); end
    checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("FAIL t1_w_m0_hready got %b exp 1", M0_HREADY); end
    next_cyc();
    M0_HWDATA = 32'hDEAD_BEEF;
    drv0(2'b10, 32'h10, 1'b0, 1'b0);
    @(negedge HCLK);
    checks++; if (S_HWDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t1_hwdata got %h exp deadbeef", S_HWDATA); end
    checks++; if (S_HWRITE !== 1'b0) begin errors++; $display("FAIL t1_r_hwrite got %b exp 0", S_HWRITE); end
    checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("FAIL t1_r_m0_hready got %b exp 1", M0_HREADY); end
    checks++; if (M1_HREADY !== 1'b1) begin errors++; $display("FAIL t1_m1_hready got %b exp 1", M1_HREADY); end
    next_cyc();
    drv0(2'b00, 32'h0, 1'b0, 1'b0);
    @(negedge HCLK);
    checks++; if (M0_HRDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t1_rdata got %h exp deadbeef", M0_HRDATA); end
    checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("FAIL t1_d_m0_hready got %b exp 1", M0_HREADY); end
    checks++; if (S_HSEL !== 1'b0) begin errors++; $display("FAIL t1_idle_hsel got %b exp 0", S_HSEL); end
    checks++; if (M0_HRESP !== 1'b0) begin errors++; $display("FAIL t1_m0_hresp got %b exp 0", M0_HRESP); end
  endtask

  task automatic test_contention;
    do_reset();
    drv0(2'b10, 32'h0, 1'b0, 1'b0);
    drv1(2'b10, 32'h4, 1'b0, 1'b0);
    @(negedge HCLK);
    checks++; if (S_HADDR !== 32'h0) begin errors++; $display("FAIL t2_c0_haddr got %h exp 0", S_HADDR); end
    checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("FAIL t2_c0_m0_hready got %b exp 1", M0_HREADY); end
    checks++; if (M1_HREADY !== 1'b1) begin errors++; $display("FAIL t2_c0_m1_hready got %b exp 1", M1_HREADY); end
    next_cyc();
    drv0(2'b00, 32'h0, 1'b0, 1'b0);
    @(negedge HCLK);
    checks++; if (M1_HREADY !== 1'b0) begin errors++; $display("FAIL t2_c1_m1_hready got %b exp 0", M1_HREADY); end
    checks++; if (S_HSEL !== 1'b1) begin errors++; $display("FAIL t2_c1_hsel got %b exp 1", S_HSEL); end
    checks++; if (S_HADDR !== 32'h4) begin errors++; $display("FAIL t2_c1_haddr got %h exp 4", S_HADDR); end
    checks++; if (M0_HRDATA !== 32'h1000_0000) begin errors++; $display("FAIL t2_m0_rdata got %h exp 10000000", M0_HRDATA); end
    next_cyc();
    drv1(2'b00, 32'h0, 1'b0, 1'b0);
    @(negedge HCLK);
    checks++; if (M1_HREADY !== 1'b1) begin errors++; $display("FAIL t2_c2_m1_hready got %b exp 1", M1_HREADY); end
    checks++; if (M1_HRDATA !== 32'h1000_0001) begin errors++; $display("FAIL t2_m1_rdata got %h exp 10000001", M1_HRDATA); end
    checks++; if (S_HSEL !== 1'b0) begin errors++; $display("FAIL t2_c2_hsel got %b exp 0", S_HSEL); end
  endtask

  task automatic test_round_robin;
    logic [31:0] exp_addr;
    do_reset();
    drv0(2'b10, 32'h20, 1'b0, 1'b0);
    drv1(2'b10, 32'h24, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_addr = (i % 2 == 0) ? 32'h20 : 32'h24;
      @(negedge HCLK);
      checks++; if (S_HADDR !== exp_addr) begin errors++; $display("FAIL t3_rr_haddr[%0d] got %h exp %h", i, S_HADDR, exp_addr); end
      checks++; if (fp_s_haddr !== 32'h20) begin errors++; $display("FAIL t3_fp_haddr[%0d] got %h exp 20", i, fp_s_haddr); end
      next_cyc();
    end
    drv0(2'b00, 32'h0, 1'b0, 1'b0);
    @(negedge HCLK);
    checks++; if (fp_s_hsel !== 1'b1) begin errors++; $display("FAIL t3_fp_m1_hsel got %b exp 1", fp_s_hsel); end
    checks++; if (fp_s_haddr !== 32'h24) begin errors++; $display("FAIL t3_fp_m1_haddr got %h exp 24", fp_s_haddr); end
  endtask

  task automatic test_lock;
    do_reset();
    drv0(2'b10, 32'h30, 1'b0, 1'b1);
    drv1(2'b10, 32'h40, 1'b0, 1'b0);
    @(negedge HCLK);
    checks++; if (S_HADDR !== 32'h30) begin errors++; $display("FAIL t4_b0_haddr got %h exp 30", S_HADDR); end
    next_cyc();
    drv0(2'b11, 32'h34, 1'b0, 1'b1);
    @(negedge HCLK);
    checks++; if (S_HADDR !== 32'h34) begin errors++; $display("FAIL t4_b1_haddr got %h exp 34", S_HADDR); end
    checks++; if (S_HTRANS !== 2'b11) begin errors++; $display("FAIL t4_b1_htrans got %b exp 11", S_HTRANS); end
    checks++; if (M1_HREADY !== 1'b0) begin errors++; $display("FAIL t4_b1_m1_hready got %b exp 0", M1_HREADY); end
    next_cyc();
    drv0(2'b11, 32'h38, 1'b0, 1'b1);
    @(negedge HCLK);
    checks++; if (S_HADDR !== 32'h38) begin errors++; $display("FAIL t4_b2_haddr got %h exp 38", S_HADDR); end
    checks++; if (M1_HREADY !== 1'b0) begin errors++; $display("FAIL t4_b2_m1_hready got %b exp 0", M1_HREADY); end
    next_cyc();
    drv0(2'b00, 32'h0, 1'b0, 1'b0);
    @(negedge HCLK);
    checks++; if (S_HSEL !== 1'b1) begin errors++; $display("FAIL t4_m1_hsel got %b exp 1", S_HSEL); end
    checks++; if (S_HADDR !== 32'h40) begin errors++; $display("FAIL t4_m1_haddr got %h exp 40", S_HADDR); end
    next_cyc();
    drv1(2'b00, 32'h0, 1'b0, 1'b0);
    @(negedge HCLK);
    checks++; if (M1_HREADY !== 1'b1) begin errors++; $display("FAIL t4_m1_done_hready got %b exp 1", M1_HREADY); end
  endtask

  task automatic test_slave_wait;
    do_reset();
    drv0(2'b10, 32'h50, 1'b1, 1'b0);
    drv1(2'b10, 32'h54, 1'b0, 1'b0);
    @(negedge HCLK);
    checks++; if (S_HADDR !== 32'h50) begin errors++; $display("FAIL t5_c0_haddr got %h exp 50", S_HADDR); end
    next_cyc();
    wait_r = 1'b1;
    M0_HWDATA = 32'hCAFE_0050;
    drv0(2'b00, 32'h0, 1'b0, 1'b0);
    drv1(2'b10, 32'h58, 1'b0, 1'b0);
    @(negedge HCLK);
    checks++; if (M0_HREADY !== 1'b0) begin errors++; $display("FAIL t5_w_m0_hready got %b exp 0", M0_HREADY); end
    checks++; if (M1_HREADY !== 1'b0) begin errors++; $display("FAIL t5_w_m1_hready got %b exp 0", M1_HREADY); end
    checks++; if (S_HSEL !== 1'b0) begin errors++; $display("FAIL t5_w_hsel got %b exp 0", S_HSEL); end
    checks++; if (S_HTRANS !== 2'b00) begin errors++; $display("FAIL t5_w_htrans got %b exp 00", S_HTRANS); end
    next_cyc();
    wait_r = 1'b0;
    @(negedge HCLK);
    checks++; if (S_HSEL !== 1'b1) begin errors++; $display("FAIL t5_r_hsel got %b exp 1", S_HSEL); end
    checks++; if (S_HADDR !== 32'h54) begin errors++; $display("FAIL t5_r_haddr got %h exp 54", S_HADDR); end
    checks++; if (S_HWRITE !== 1'b0) begin errors++; $display("FAIL t5_r_hwrite got %b exp 0", S_HWRITE); end
    checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("FAIL t5_r_m0_hready got %b exp 1", M0_HREADY); end
    checks++; if (M1_HREADY !== 1'b0) begin errors++; $display("FAIL t5_r_m1_hready got %b exp 0", M1_HREADY); end
    next_cyc();
    drv1(2'b00, 32'h0, 1'b0, 1'b0);
    @(negedge HCLK);
    checks++; if (M1_HREADY !== 1'b1) begin errors++; $display("FAIL t5_d_m1_hready got %b exp 1", M1_HREADY); end
    checks++; if (M1_HRDATA !== 32'h1000_0015) begin errors++; $display("FAIL t5_m1_rdata got %h exp 10000015", M1_HRDATA); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    drv0(2'b10, 32'h0, 1'b0, 1'b0);
    drv1(2'b10, 32'h4, 1'b0, 1'b0);
    next_cyc();
    drv0(2'b00, 32'h0, 1'b0, 1'b0);
    @(negedge HCLK);
    checks++; if (M1_HREADY !== 1'b0) begin errors++; $display("FAIL t6_pre_m1_hready got %b exp 0", M1_HREADY); end
    #1;
    HRESETn = 1'b0;
    idle_all();
    #1;
    checks++; if (S_HTRANS !== 2'b00) begin errors++; $display("FAIL t6_a_htrans got %b exp 00", S_HTRANS); end
    checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("FAIL t6_a_m0_hready got %b exp 1", M0_HREADY); end
    checks++; if (M1_HREADY !== 1'b1) begin errors++; $display("FAIL t6_a_m1_hready got %b exp 1", M1_HREADY); end
    next_cyc();
    checks++; if (S_HTRANS !== 2'b00) begin errors++; $display("FAIL t6_b_htrans got %b exp 00", S_HTRANS); end
    checks++; if (S_HSEL !== 1'b0) begin errors++; $display("FAIL t6_b_hsel got %b exp 0", S_HSEL); end
    checks++; if (M1_HREADY !== 1'b1) begin errors++; $display("FAIL t6_b_m1_hready got %b exp 1", M1_HREADY); end
    HRESETn = 1'b1;
    @(negedge HCLK);
    checks++; if (S_HSEL !== 1'b0) begin errors++; $display("FAIL t6_post_hsel got %b exp 0", S_HSEL); end
    checks++; if (M1_HREADY !== 1'b1) begin errors++; $display("FAIL t6_post_m1_hready got %b exp 1", M1_HREADY); end
    checks++; if (M0_HREADY !== 1'b1) begin errors++; $display("FAIL t6_post_m0_hready got %b exp 1", M0_HREADY); end
  endtask

  initial begin
    test_reset();
    test_m0_alone();
    test_contention();
    test_round_robin();
    test_lock();
    test_slave_wait();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
